// File: rtl/pwm_capture_if.sv
// Register read port of pwm_capture: PWM input, clear, read select, read data and capture strobe.
interface pwm_capture_if #(
    parameter int unsigned W = 16
);
    logic         in;
    logic         clr;
    logic [1:0]   sel;
    logic [W-1:0] q;
    logic         cap;

    modport master (output in, clr, sel, input  q, cap);
    modport slave  (input  in, clr, sel, output q, cap);
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes an asynchronous PWM input and measures its period and high time
// between consecutive rising edges, exposed through a sel-addressed read mux.
module pwm_capture #(
    parameter int unsigned W    = 16,
    parameter int unsigned SYNC = 2
) (
    input  logic         clk,
    input  logic         nrst,
    pwm_capture_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    state_t          state_q, state_d;
    logic [SYNC-1:0] sync_q, sync_d;
    logic            in_d_q, in_d_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    hcnt_q, hcnt_d;
    logic [W-1:0]    period_q, period_d;
    logic [W-1:0]    high_q, high_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;

    logic in_s;
    logic rise;
    logic at_max;

    assign in_s   = sync_q[SYNC-1];
    assign rise   = in_s & ~in_d_q;
    assign at_max = (cnt_q == CNT_MAX);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            in_d_q    <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            in_d_q    <= in_d_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; clr wins over any rise in the same cycle
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (rise) state_d = MEAS;
                MEAS:    if (!rise && at_max) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and flag updates
    always_comb begin
        sync_d    = {sync_q[SYNC-2:0], bus.in};
        in_d_d    = in_s;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        bus.cap   = 1'b0;
        if (bus.clr) begin
            cnt_d     = '0;
            hcnt_d    = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (rise) begin
                cnt_d  = CNT_ONE;
                hcnt_d = CNT_ONE;
            end
        end else if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            bus.cap  = 1'b1;
            cnt_d    = CNT_ONE;
            hcnt_d   = CNT_ONE;
        end else if (at_max) begin
            // Counter saturated without a rise: give up and hold cnt for readback
            timeout_d = 1'b1;
            valid_d   = 1'b0;
        end else begin
            cnt_d  = cnt_q + CNT_ONE;
            hcnt_d = hcnt_q + W'(in_s);
        end
    end

    // Read mux
    always_comb begin
        case (bus.sel)
            2'd0:    bus.q = {{(W-3){1'b0}}, timeout_q, valid_q, in_s};
            2'd1:    bus.q = high_q;
            2'd2:    bus.q = period_q;
            default: bus.q = cnt_q;
        endcase
    end
endmodule
